// File: rtl/ram_if_pkg.sv
// Shared types and helpers for the two-client Ram_if arbiter.
//   client_sel_t : index of a client (0 = instruction fetch, 1 = data access)
//   N_CLIENTS    : number of arbitrated clients
//   ADDR_W, DATA_W, BE_W : Ram_if field widths
//   rr_next()    : client preferred after the given one completes
package ram_if_pkg;

   localparam int unsigned N_CLIENTS = 2;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned BE_W      = DATA_W / 8;

   typedef logic [0:0] client_sel_t;

   function automatic client_sel_t rr_next(client_sel_t sel);
      return ~sel;
   endfunction

endpackage

// File: rtl/ram_if.sv
// Ram_if bundle: single-cycle request/response memory port with a delay stall.
//   memory modport : seen by the block that serves requests (en..be in; data_r, delay out)
//   client modport : seen by the block that issues requests (en..be out; data_r, delay in)
interface ram_if;

   logic                             en;
   logic [ram_if_pkg::ADDR_W-1:0]    addr;
   logic [ram_if_pkg::DATA_W-1:0]    data_w;
   logic                             we;
   logic [ram_if_pkg::BE_W-1:0]      be;
   logic [ram_if_pkg::DATA_W-1:0]    data_r;
   logic                             delay;

   modport memory (
      input  en, addr, data_w, we, be,
      output data_r, delay
   );

   modport client (
      output en, addr, data_w, we, be,
      input  data_r, delay
   );

endinterface

// File: rtl/ram_if_rr_arb.sv
// Pure combinational two-way arbitration decision.
//   req      : per-client request (en) vector
//   lock     : hold the grant on lock_sel regardless of requests
//   lock_sel : current owner, also the idle selection
//   prio     : client that wins when both request
//   sel      : selected client
module ram_if_rr_arb
   import ram_if_pkg::*;
(
   input  logic [N_CLIENTS-1:0] req,
   input  logic                 lock,
   input  client_sel_t          lock_sel,
   input  client_sel_t          prio,
   output client_sel_t          sel
);

   always_comb begin
      sel = lock_sel;
      if (!lock) begin
         unique case (req)
            2'b01:   sel = client_sel_t'(0);
            2'b10:   sel = client_sel_t'(1);
            2'b11:   sel = prio;
            default: sel = lock_sel;
         endcase
      end
   end

endmodule

// File: rtl/ram_if_arbiter2.sv
// Merges two Ram_if masters onto one Ram_if root. The winner is forwarded with no added
// latency; a loser is stalled with delay for the following cycle. Responses are steered
// by the registered owner so the response path is independent of the next request.
//   clk, reset : clock and synchronous active-high reset
//   client_0   : instruction-fetch request port
//   client_1   : data-access request port
//   mem        : merged request toward the split tree
module ram_if_arbiter2
   import ram_if_pkg::*;
#(
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned LOCK_ON_DELAY  = 1
) (
   input logic   clk,
   input logic   reset,
   ram_if.memory client_0,
   ram_if.memory client_1,
   ram_if.client mem
);

   if (LOCK_ON_DELAY != 1) begin : g_lock_check
      $error("ram_if_arbiter2: LOCK_ON_DELAY=0 is not supported");
   end

   client_sel_t          owner_q;
   logic                 pend_q;
   logic [N_CLIENTS-1:0] denied_q;
   client_sel_t          prio_q;

   logic [N_CLIENTS-1:0] req;
   logic                 lock;
   logic                 done;
   client_sel_t          prio_eff;
   client_sel_t          arb_prio;
   client_sel_t          sel;
   logic                 fwd_en;

   always_comb begin
      req  = {client_1.en, client_0.en};
      lock = pend_q & mem.delay;
      done = pend_q & ~mem.delay;
      // A completion this cycle already flips the preference for a conflict this cycle.
      prio_eff = done ? rr_next(owner_q) : prio_q;
      arb_prio = (FIXED_PRIORITY != 0) ? client_sel_t'(0) : prio_eff;
   end

   ram_if_rr_arb u_arb (
      .req      (req),
      .lock     (lock),
      .lock_sel (owner_q),
      .prio     (arb_prio),
      .sel      (sel)
   );

   always_comb begin
      if (sel == client_sel_t'(1)) begin
         fwd_en     = client_1.en;
         mem.addr   = client_1.addr;
         mem.data_w = client_1.data_w;
         mem.be     = client_1.be;
         mem.we     = client_1.we & ~reset;
      end else begin
         fwd_en     = client_0.en;
         mem.addr   = client_0.addr;
         mem.data_w = client_0.data_w;
         mem.be     = client_0.be;
         mem.we     = client_0.we & ~reset;
      end
      fwd_en = fwd_en & ~reset;
      mem.en = fwd_en;

      client_0.data_r = mem.data_r;
      client_1.data_r = mem.data_r;
      client_0.delay  = ~reset &
                        (denied_q[0] | ((owner_q == client_sel_t'(0)) & lock));
      client_1.delay  = ~reset &
                        (denied_q[1] | ((owner_q == client_sel_t'(1)) & lock));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= client_sel_t'(0);
         pend_q   <= 1'b0;
         denied_q <= '0;
         prio_q   <= client_sel_t'(0);
      end else begin
         owner_q     <= sel;
         pend_q      <= fwd_en;
         denied_q[0] <= client_0.en & (sel != client_sel_t'(0));
         denied_q[1] <= client_1.en & (sel != client_sel_t'(1));
         if (done) begin
            prio_q <= rr_next(sel);
         end
      end
   end

endmodule

// File: tb/tb_ram_if_arbiter2.sv
module tb_ram_if_arbiter2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ram_if c0_rr ();
   ram_if c1_rr ();
   ram_if m_rr ();
   ram_if c0_fp ();
   ram_if c1_fp ();
   ram_if m_fp ();

   ram_if_arbiter2 #(
      .FIXED_PRIORITY (0),
      .LOCK_ON_DELAY  (1)
   ) dut_rr (
      .clk      (clk),
      .reset    (reset),
      .client_0 (c0_rr),
      .client_1 (c1_rr),
      .mem      (m_rr)
   );

   ram_if_arbiter2 #(
      .FIXED_PRIORITY (1),
      .LOCK_ON_DELAY  (1)
   ) dut_fp (
      .clk      (clk),
      .reset    (reset),
      .client_0 (c0_fp),
      .client_1 (c1_fp),
      .mem      (m_fp)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c0_rr.en = 0; c0_rr.we = 0; c0_rr.addr = '0; c0_rr.data_w = '0; c0_rr.be = '0;
      c1_rr.en = 0; c1_rr.we = 0; c1_rr.addr = '0; c1_rr.data_w = '0; c1_rr.be = '0;
      c0_fp.en = 0; c0_fp.we = 0; c0_fp.addr = '0; c0_fp.data_w = '0; c0_fp.be = '0;
      c1_fp.en = 0; c1_fp.we = 0; c1_fp.addr = '0; c1_fp.data_w = '0; c1_fp.be = '0;
      m_rr.data_r = '0; m_rr.delay = 0;
      m_fp.data_r = '0; m_fp.delay = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      c0_rr.en = 1; c0_rr.we = 1; c1_rr.en = 1;
      #1;
      total++;
      if (m_rr.en !== 1'b0) begin
         bad++; $display("FAIL reset_mem_en: got %b want 0", m_rr.en);
      end
      total++;
      if (m_rr.we !== 1'b0) begin
         bad++; $display("FAIL reset_mem_we: got %b want 0", m_rr.we);
      end
      cyc();
      total++;
      if (c0_rr.delay !== 1'b0 || c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL reset_delays: got %b%b want 00", c1_rr.delay, c0_rr.delay);
      end
      idle();
      reset = 0;
      #1;
      total++;
      if (m_rr.en !== 1'b0 || c0_rr.delay !== 1'b0 || c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL post_reset_idle: got en=%b d0=%b d1=%b want 0 0 0",
                         m_rr.en, c0_rr.delay, c1_rr.delay);
      end
      cyc();
   endtask

   task automatic test_single();
      do_reset();
      c0_rr.en = 1; c0_rr.addr = 32'h100; c0_rr.be = 4'hF;
      #1;
      total++;
      if (m_rr.en !== 1'b1 || m_rr.addr !== 32'h100) begin
         bad++; $display("FAIL single_fwd: got en=%b addr=%h want 1 00000100", m_rr.en, m_rr.addr);
      end
      cyc();
      c0_rr.en = 0;
      m_rr.data_r = 32'hCAFE0001;
      #1;
      total++;
      if (c0_rr.data_r !== 32'hCAFE0001) begin
         bad++; $display("FAIL single_data: got %h want cafe0001", c0_rr.data_r);
      end
      total++;
      if (c0_rr.delay !== 1'b0 || c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL single_delay: got %b%b want 00", c1_rr.delay, c0_rr.delay);
      end
      cyc();
      idle();
   endtask

   task automatic test_conflict();
      do_reset();
      c0_rr.en = 1; c0_rr.addr = 32'h10;
      c1_rr.en = 1; c1_rr.addr = 32'h8000_0020;
      #1;
      total++;
      if (m_rr.addr !== 32'h10 || m_rr.en !== 1'b1) begin
         bad++; $display("FAIL conflict_t0_addr: got en=%b addr=%h want 1 00000010",
                         m_rr.en, m_rr.addr);
      end
      total++;
      if (c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL conflict_t0_d1: got %b want 0", c1_rr.delay);
      end
      cyc();
      c0_rr.en = 0;
      m_rr.data_r = 32'h0000_00A0;
      #1;
      total++;
      if (c0_rr.data_r !== 32'h0000_00A0) begin
         bad++; $display("FAIL conflict_t1_data0: got %h want 000000a0", c0_rr.data_r);
      end
      total++;
      if (c1_rr.delay !== 1'b1) begin
         bad++; $display("FAIL conflict_t1_d1: got %b want 1", c1_rr.delay);
      end
      total++;
      if (m_rr.addr !== 32'h8000_0020 || m_rr.en !== 1'b1) begin
         bad++; $display("FAIL conflict_t1_addr: got en=%b addr=%h want 1 80000020",
                         m_rr.en, m_rr.addr);
      end
      cyc();
      c1_rr.en = 0;
      m_rr.data_r = 32'h0000_00B1;
      #1;
      total++;
      if (c1_rr.delay !== 1'b0 || c1_rr.data_r !== 32'h0000_00B1) begin
         bad++; $display("FAIL conflict_t2_data1: got d=%b data=%h want 0 000000b1",
                         c1_rr.delay, c1_rr.data_r);
      end
      cyc();
      idle();
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr;
      do_reset();
      c0_rr.en = 1; c0_rr.addr = 32'hA0;
      c1_rr.en = 1; c1_rr.addr = 32'hB0;
      for (int i = 0; i < 8; i++) begin
         exp_addr = (i % 2 == 0) ? 32'hA0 : 32'hB0;
         #1;
         total++;
         if (m_rr.en !== 1'b1 || m_rr.addr !== exp_addr) begin
            bad++; $display("FAIL rr_seq[%0d]: got en=%b addr=%h want 1 %h",
                            i, m_rr.en, m_rr.addr, exp_addr);
         end
         cyc();
      end
      idle();
      cyc();
   endtask

   task automatic test_downstream_delay();
      int writes;
      writes = 0;
      do_reset();
      // Cycle A: client_1 write alone.
      c1_rr.en = 1; c1_rr.we = 1; c1_rr.addr = 32'h200;
      c1_rr.data_w = 32'hDEADBEEF; c1_rr.be = 4'hF;
      #1;
      total++;
      if (m_rr.en !== 1'b1 || m_rr.we !== 1'b1 || m_rr.data_w !== 32'hDEADBEEF) begin
         bad++; $display("FAIL dly_issue: got en=%b we=%b data=%h want 1 1 deadbeef",
                         m_rr.en, m_rr.we, m_rr.data_w);
      end
      if (m_rr.en && m_rr.we && !m_rr.delay) writes++;
      cyc();
      // Cycles A+1..A+3: downstream stalls; client_0 starts requesting.
      c0_rr.en = 1; c0_rr.addr = 32'h300;
      m_rr.delay = 1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         total++;
         if (m_rr.addr !== 32'h200 || m_rr.we !== 1'b1 || m_rr.data_w !== 32'hDEADBEEF) begin
            bad++; $display("FAIL dly_hold[%0d]: got addr=%h we=%b data=%h want 00000200 1 deadbeef",
                            k, m_rr.addr, m_rr.we, m_rr.data_w);
         end
         total++;
         if (c1_rr.delay !== 1'b1) begin
            bad++; $display("FAIL dly_owner_d[%0d]: got %b want 1", k, c1_rr.delay);
         end
         if (k > 1) begin
            total++;
            if (c0_rr.delay !== 1'b1) begin
               bad++; $display("FAIL dly_other_d[%0d]: got %b want 1", k, c0_rr.delay);
            end
         end
         if (m_rr.en && m_rr.we && !m_rr.delay) writes++;
         cyc();
      end
      // Cycle A+4: write completes; client_0 is forwarded.
      m_rr.delay = 0;
      m_rr.data_r = 32'h1111_2222;
      c1_rr.en = 0; c1_rr.we = 0;
      #1;
      total++;
      if (c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL dly_done_d1: got %b want 0", c1_rr.delay);
      end
      total++;
      if (c0_rr.delay !== 1'b1) begin
         bad++; $display("FAIL dly_done_d0: got %b want 1", c0_rr.delay);
      end
      total++;
      if (m_rr.en !== 1'b1 || m_rr.addr !== 32'h300 || m_rr.we !== 1'b0) begin
         bad++; $display("FAIL dly_serve0: got en=%b addr=%h we=%b want 1 00000300 0",
                         m_rr.en, m_rr.addr, m_rr.we);
      end
      if (m_rr.en && m_rr.we && !m_rr.delay) writes++;
      cyc();
      c0_rr.en = 0;
      m_rr.data_r = 32'h3333_4444;
      #1;
      total++;
      if (c0_rr.delay !== 1'b0 || c0_rr.data_r !== 32'h3333_4444) begin
         bad++; $display("FAIL dly_resp0: got d=%b data=%h want 0 33334444",
                         c0_rr.delay, c0_rr.data_r);
      end
      total++;
      if (writes != 1) begin
         bad++; $display("FAIL dly_write_count: got %0d want 1", writes);
      end
      cyc();
      idle();
   endtask

   task automatic test_fixed_priority();
      do_reset();
      c0_fp.en = 1; c0_fp.addr = 32'h40;
      c1_fp.en = 1; c1_fp.addr = 32'h50;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++;
         if (m_fp.en !== 1'b1 || m_fp.addr !== 32'h40) begin
            bad++; $display("FAIL fp_grant[%0d]: got en=%b addr=%h want 1 00000040",
                            i, m_fp.en, m_fp.addr);
         end
         total++;
         if (c1_fp.delay !== ((i == 0) ? 1'b0 : 1'b1)) begin
            bad++; $display("FAIL fp_d1[%0d]: got %b want %b", i, c1_fp.delay, (i != 0));
         end
         cyc();
      end
      idle();
      cyc();
   endtask

   task automatic test_reset_mid();
      do_reset();
      c0_rr.en = 1; c0_rr.addr = 32'h600;
      cyc();
      m_rr.delay = 1;
      #1;
      total++;
      if (c0_rr.delay !== 1'b1) begin
         bad++; $display("FAIL rmid_locked: got %b want 1", c0_rr.delay);
      end
      cyc();
      reset = 1;
      #1;
      total++;
      if (m_rr.en !== 1'b0 || c0_rr.delay !== 1'b0 || c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL rmid_in_reset: got en=%b d0=%b d1=%b want 0 0 0",
                         m_rr.en, c0_rr.delay, c1_rr.delay);
      end
      cyc();
      reset = 0;
      c0_rr.en = 0;
      c1_rr.en = 1; c1_rr.addr = 32'h700;
      #1;
      total++;
      if (m_rr.en !== 1'b1 || m_rr.addr !== 32'h700) begin
         bad++; $display("FAIL rmid_nolock: got en=%b addr=%h want 1 00000700",
                         m_rr.en, m_rr.addr);
      end
      total++;
      if (c0_rr.delay !== 1'b0 || c1_rr.delay !== 1'b0) begin
         bad++; $display("FAIL rmid_delays: got %b%b want 00", c1_rr.delay, c0_rr.delay);
      end
      cyc();
      idle();
   endtask

   initial begin
      idle();
      cyc();
      test_reset();
      test_single();
      test_conflict();
      test_round_robin();
      test_downstream_delay();
      test_fixed_priority();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_if_arbiter2.md
Name: ram_if_arbiter2

Overview:
- Two-client to one-memory Ram_if arbiter.
- Sits directly upstream of the address-split tree. It merges the instruction-fetch and data-access Ram_if masters onto the single Ram_if root that feeds the split.
- Forwards requests from the winning client and stalls the losing client via delay.
- Routes data_r/delay back using a registered grant, so the response mux is decoupled from the next request.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between clients; 1 = client_0 always wins on conflict.
- LOCK_ON_DELAY, 1, 1 = the grant stays with the owner while the downstream asserts delay. 0 is not supported; the elaboration-time check fails.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- client_0  Ram_if.memory  -  request port 0 (instruction fetch); en, addr, data_w, we, be in; data_r, delay out.
- client_1  Ram_if.memory  -  request port 1 (data access); same fields.
- mem  Ram_if.client  -  merged request toward the split tree; en, addr, data_w, we, be out; data_r, delay in.

Behaviour:
- Ram_if protocol:
  - A request is presented with en=1 in cycle t.
  - The response is valid in t+1 when delay=0.
  - While delay=1 the master holds en and all request fields stable and re-presents them each cycle.
- State (all registered, reset values in brackets):
  - owner_q [0]: client whose request was forwarded last cycle.
  - pend_q [0]: a forwarded request is outstanding.
  - denied_q[1:0] [00]: client requested last cycle but was not forwarded.
  - prio_q [0]: client preferred on the next conflict.
- Arbitration (combinational, per cycle):
  - Lock: if pend_q=1 and mem.delay=1, then sel=owner_q. This overrides all other rules.
  - Otherwise, if exactly one client has en=1, sel=that client.
  - Otherwise, if both have en=1: sel=0 if FIXED_PRIORITY=1, else sel=prio_q.
  - Otherwise (no request), sel=owner_q and mem.en=0.
- Request forwarding:
  - mem.addr, data_w and be = the selected client's fields.
  - mem.en and mem.we = the selected client's en and we.
  - A non-selected client's en/we are never forwarded.
- State update at posedge clk:
  - owner_q <= sel.
  - pend_q <= mem.en.
  - denied_q[i] <= client_i.en & (sel != i).
  - prio_q <= ~sel when a forwarded request completes, i.e. pend_q=1 and mem.delay=0.
- Responses:
  - client_i.data_r = mem.data_r for both clients; it is only meaningful for the owner.
  - client_i.delay = denied_q[i] | (owner_q==i & pend_q & mem.delay).
- Latency: the granted client sees no added latency over the bare split tree (zero extra cycles). A denied client sees at least +1 cycle per lost arbitration.
- Fairness: with round-robin and both clients requesting continuously, grants alternate 0,1,0,1. Neither client waits more than one completed transaction.
- Lock: the owner keeps the grant for the whole duration of downstream delay. The other client's delay stays 1 throughout.
- Simultaneous events: completion of the owner and a new conflict in the same cycle use the already-flipped preference. prio_q is used combinationally as ~owner_q when completion occurs in that cycle.
- Reset:
  - While reset=1: mem.en=0 and mem.we=0, both client delay outputs are 0, and all state takes its reset value.
  - Reset asserted mid-transaction abandons the outstanding request. After reset, mem.delay is ignored until a new request is forwarded.
- No request is ever duplicated to memory. A write (we=1) is forwarded once per acceptance; re-presentation is only under delay.

Decomposition:
- ram_if_pkg: typedef client_sel_t (logic [0:0]), constant N_CLIENTS=2, function rr_next(sel).
- One sub-module is natural: ram_if_rr_arb. It holds pure arbitration: inputs req[1:0], lock, lock_sel, prio; output sel. The Ram_if muxing and state registers stay in the top.

Test Plan:
- Single client: client_0 read addr 0x100, mem.data_r=0xCAFE0001 at t+1, no delay -> client_0 receives 0xCAFE0001 at t+1; client_0.delay=0; client_1.delay=0.
- Conflict, round-robin: both en at t (client_0 addr 0x10, client_1 addr 0x8000_0020) -> mem.addr=0x10 at t; client_1.delay=1 at t+1; mem.addr=0x8000_0020 at t+1; client_1 gets its data at t+2.
- Continuous conflict, 8 cycles -> forwarded owner sequence is exactly 0,1,0,1,0,1,0,1.
- Downstream delay: client_1 write 0xDEADBEEF granted, mem.delay=1 for 3 cycles while client_0 also requests -> mem stays client_1's write for 3 cycles; client_0.delay=1 throughout; client_0 is served in the cycle after delay drops; the write issues exactly once.
- FIXED_PRIORITY=1 with both clients requesting every cycle -> client_0 granted every cycle; client_1.delay=1 continuously.
- Reset asserted during an outstanding delayed request -> next cycle mem.en=0 and both client delays 0; first post-reset request forwarded with no lock.
